// File: rtl/xbar_sched.sv
// Per-egress round-robin crossbar scheduler. Each egress locks to one ingress until
// end-of-packet or an idle-owner timeout, then spends one bubble cycle before re-arbitrating.
module xbar_sched #(
  parameter int unsigned XBAR_INPUT    = 4,
  parameter int unsigned XBAR_INPUT_L2 = $clog2(XBAR_INPUT),
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [XBAR_INPUT-1:0]                    req_valid,
  input  logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0] req_dest,
  input  logic [XBAR_INPUT-1:0]                    req_eop,
  output logic [XBAR_INPUT-1:0]                    req_grant,
  output logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0] xbar_arbit,
  output logic [XBAR_INPUT-1:0]                    xbar_busy,
  output logic [XBAR_INPUT-1:0]                    lock_timeout
);

  localparam int unsigned CntW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);
  localparam logic [XBAR_INPUT_L2-1:0] PtrRst = XBAR_INPUT_L2'(XBAR_INPUT - 1);

  typedef enum logic [1:0] {StIdle, StLocked, StRelease} state_e;

  logic [XBAR_INPUT-1:0]                    w_grant;
  logic [XBAR_INPUT-1:0]                    w_busy;
  logic [XBAR_INPUT-1:0]                    w_tmo;
  logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0] w_arbit;

  // Grants are derived purely from registered egress state, so they cannot glitch.
  always_comb begin
    w_grant = '0;
    for (int n = 0; n < XBAR_INPUT; n++) begin
      if (w_busy[n]) begin
        w_grant[w_arbit[n]] = 1'b1;
      end
    end
  end

  for (genvar n = 0; n < XBAR_INPUT; n++) begin : g_egress
    state_e                    r_state;
    logic [XBAR_INPUT_L2-1:0]  r_arbit;
    logic [XBAR_INPUT_L2-1:0]  r_ptr;
    logic                      r_busy;
    logic                      r_tmo;
    logic [CntW-1:0]           r_cnt;
    logic [XBAR_INPUT-1:0]     w_cand;
    logic                      w_found;
    logic [XBAR_INPUT_L2-1:0]  w_win;
    logic [XBAR_INPUT_L2-1:0]  w_idx;
    logic                      w_own_valid;
    logic                      w_xfer;

    always_comb begin
      w_cand = '0;
      for (int i = 0; i < XBAR_INPUT; i++) begin
        w_cand[i] = req_valid[i] && (req_dest[i] == XBAR_INPUT_L2'(n)) && !w_grant[i];
      end
    end

    // Search starts one past the last owner so the previous winner ranks last.
    always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int unsigned k = 1; k <= XBAR_INPUT; k++) begin
        w_idx = XBAR_INPUT_L2'((32'(r_ptr) + k) % XBAR_INPUT);
        if (!w_found && w_cand[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end

    assign w_own_valid = req_valid[r_arbit];
    assign w_xfer      = w_own_valid && w_grant[r_arbit];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state <= StIdle;
        r_arbit <= '0;
        r_ptr   <= PtrRst;
        r_busy  <= 1'b0;
        r_tmo   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_tmo <= 1'b0;
        unique case (r_state)
          StIdle: begin
            if (w_found) begin
              r_state <= StLocked;
              r_arbit <= w_win;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end
          end
          StLocked: begin
            if (w_xfer && req_eop[r_arbit]) begin
              r_state <= StRelease;
              r_busy  <= 1'b0;
              r_ptr   <= r_arbit;
              r_cnt   <= '0;
            end else if (w_own_valid) begin
              r_cnt <= '0;
            end else if (LOCK_TIMEOUT != 0 && r_cnt == CntLast) begin
              r_state <= StRelease;
              r_busy  <= 1'b0;
              r_ptr   <= r_arbit;
              r_tmo   <= 1'b1;
              r_cnt   <= '0;
            end else if (LOCK_TIMEOUT != 0) begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
          StRelease: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end

    assign w_busy[n]  = r_busy;
    assign w_arbit[n] = r_arbit;
    assign w_tmo[n]   = r_tmo;
  end

  assign req_grant    = w_grant;
  assign xbar_busy    = w_busy;
  assign xbar_arbit   = w_arbit;
  assign lock_timeout = w_tmo;

endmodule
